// File: rtl/conv_sequencer_if.sv
// conv_sequencer_if: handshake, memory and convolver bundle of the frame sequencer.
// The master side is the sequencer; the slave side is its environment.
interface conv_sequencer_if #(
   parameter int AW = 10,
   parameter int RW = 10,
   parameter int K  = 3
);
   logic                  start;
   logic                  reuse_w;
   logic                  busy;
   logic                  done;
   logic                  err;
   logic [15:0]           w_data;
   logic                  w_valid;
   logic                  w_ready;
   logic                  act_rd_en;
   logic [AW-1:0]         act_addr;
   logic [15:0]           act_rd_data;
   logic                  conv_rst;
   logic                  conv_ce;
   logic [16*K*K-1:0]     conv_weight;
   logic [15:0]           conv_act;
   logic [31:0]           conv_op;
   logic                  valid_conv;
   logic                  end_conv;
   logic                  end_flag;
   logic                  res_wr_en;
   logic [RW-1:0]         res_addr;
   logic [31:0]           res_wr_data;

   modport master (
      input  start, reuse_w, w_data, w_valid, act_rd_data,
      input  conv_op, valid_conv, end_conv,
      output busy, done, err, w_ready, act_rd_en, act_addr,
      output conv_rst, conv_ce, conv_weight, conv_act, end_flag,
      output res_wr_en, res_addr, res_wr_data
   );

   modport slave (
      output start, reuse_w, w_data, w_valid, act_rd_data,
      output conv_op, valid_conv, end_conv,
      input  busy, done, err, w_ready, act_rd_en, act_addr,
      input  conv_rst, conv_ce, conv_weight, conv_act, end_flag,
      input  res_wr_en, res_addr, res_wr_data
   );
endinterface

// File: rtl/conv_sequencer.sv
// conv_sequencer: runs one convolution frame -- weight load, convolver clear,
// feature-map stream, pipeline drain with watchdog, and result write-back.
module conv_sequencer #(
   parameter int N         = 4,
   parameter int K         = 3,
   parameter int S         = 1,
   parameter int AW        = 10,
   parameter int RW        = 10,
   parameter int DRAIN_MAX = 64
) (
   input  logic             clk,
   input  logic             global_rst,
   conv_sequencer_if.master bus
);
   localparam int OUT_DIM = (N - K) / S + 1;
   localparam int EXP     = OUT_DIM * OUT_DIM;
   localparam int KK      = K * K;
   localparam int WIW     = $clog2(KK + 1);
   localparam int OCW     = $clog2(EXP + 1);
   localparam int DCW     = $clog2(DRAIN_MAX + 1);

   localparam logic [WIW-1:0] WI_LAST   = WIW'(KK - 1);
   localparam logic [OCW-1:0] OC_EXP    = OCW'(EXP);
   localparam logic [DCW-1:0] DC_LAST   = DCW'(DRAIN_MAX - 1);
   localparam logic [AW-1:0]  ADDR_LAST = AW'(N * N - 1);

   typedef enum logic [2:0] {
      IDLE, LOAD_W, CLR, STREAM, DRAIN, DONE
   } state_t;

   state_t         state;
   logic [WIW-1:0] wi;
   logic [OCW-1:0] oc;
   logic [DCW-1:0] dc;
   logic           rd_valid;
   logic           capture;
   logic           in_run;

   assign in_run  = (state == STREAM) || (state == DRAIN);
   assign capture = in_run && bus.valid_conv && (oc < OC_EXP);

   // RAM data is presented the cycle after the read; drain cycles feed zeros.
   assign bus.conv_act = rd_valid ? bus.act_rd_data : 16'h0000;

   always_ff @(posedge clk) begin
      if (global_rst) begin
         state           <= IDLE;
         wi              <= '0;
         oc              <= '0;
         dc              <= '0;
         rd_valid        <= 1'b0;
         bus.busy        <= 1'b0;
         bus.done        <= 1'b0;
         bus.err         <= 1'b0;
         bus.w_ready     <= 1'b0;
         bus.act_rd_en   <= 1'b0;
         bus.act_addr    <= '0;
         bus.conv_rst    <= 1'b0;
         bus.conv_ce     <= 1'b0;
         bus.conv_weight <= '0;
         bus.end_flag    <= 1'b0;
         bus.res_wr_en   <= 1'b0;
         bus.res_addr    <= '0;
         bus.res_wr_data <= '0;
      end else begin
         bus.done      <= 1'b0;
         bus.conv_rst  <= 1'b0;
         bus.res_wr_en <= capture;
         rd_valid      <= bus.act_rd_en;

         if (bus.end_conv) begin
            bus.end_flag <= 1'b1;
         end

         if (capture) begin
            bus.res_addr    <= RW'(oc);
            bus.res_wr_data <= bus.conv_op;
            oc              <= oc + 1'b1;
         end

         unique case (state)
            IDLE: begin
               if (bus.start) begin
                  bus.busy     <= 1'b1;
                  bus.err      <= 1'b0;
                  bus.end_flag <= 1'b0;
                  wi           <= '0;
                  if (bus.reuse_w) begin
                     state        <= CLR;
                     bus.conv_rst <= 1'b1;
                  end else begin
                     state       <= LOAD_W;
                     bus.w_ready <= 1'b1;
                  end
               end
            end
            LOAD_W: begin
               if (bus.w_valid && bus.w_ready) begin
                  bus.conv_weight[int'(wi)*16 +: 16] <= bus.w_data;
                  wi <= wi + 1'b1;
                  if (wi == WI_LAST) begin
                     bus.w_ready  <= 1'b0;
                     bus.conv_rst <= 1'b1;
                     state        <= CLR;
                  end
               end
            end
            CLR: begin
               oc            <= '0;
               dc            <= '0;
               bus.act_addr  <= '0;
               bus.act_rd_en <= 1'b1;
               state         <= STREAM;
            end
            STREAM: begin
               bus.conv_ce <= 1'b1;
               if (bus.act_addr == ADDR_LAST) begin
                  bus.act_rd_en <= 1'b0;
                  bus.act_addr  <= '0;
                  state         <= DRAIN;
               end else begin
                  bus.act_addr <= bus.act_addr + 1'b1;
               end
            end
            DRAIN: begin
               if (oc == OC_EXP || dc == DC_LAST) begin
                  if (oc != OC_EXP) begin
                     bus.err <= 1'b1;
                  end
                  bus.conv_ce <= 1'b0;
                  bus.done    <= 1'b1;
                  bus.busy    <= 1'b0;
                  state       <= DONE;
               end else begin
                  dc <= dc + 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_conv_sequencer.sv
// tb_conv_sequencer: directed and randomized frames against a behavioural
// convolver stub, activation RAM and an arithmetic reference of the results.
module tb_conv_sequencer;
   localparam int N       = 4;
   localparam int K       = 3;
   localparam int S       = 1;
   localparam int OUT_DIM = (N - K) / S + 1;
   localparam int EXP     = OUT_DIM * OUT_DIM;

   logic clk = 1'b0;
   logic global_rst;

   conv_sequencer_if #(.AW(10), .RW(10), .K(K)) bus ();

   conv_sequencer #(
      .N(N), .K(K), .S(S), .AW(10), .RW(10), .DRAIN_MAX(64)
   ) dut (
      .clk        (clk),
      .global_rst (global_rst),
      .bus        (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   logic [15:0] wts     [0:K*K-1];
   logic [15:0] act_mem [0:N*N-1];

   bit stub_mute;
   bit stub_extra;
   int stub_lat;

   always @(posedge clk) cyc <= cyc + 1;

   // activation RAM, one-cycle read latency
   always @(posedge clk) begin
      if (global_rst) bus.act_rd_data <= '0;
      else if (bus.act_rd_en && int'(bus.act_addr) < N*N)
         bus.act_rd_data <= act_mem[int'(bus.act_addr)];
   end

   // convolver stub: keeps the streamed samples and emits each window sum
   // stub_lat samples after the window's last pixel arrived
   int          scnt;
   logic [15:0] samp [0:127];
   logic [31:0] acc;
   always @(posedge clk) begin
      bus.valid_conv <= 1'b0;
      bus.end_conv   <= 1'b0;
      if (global_rst) begin
         scnt        <= 0;
         bus.conv_op <= '0;
      end else if (bus.conv_rst) begin
         scnt <= 0;
      end else if (bus.conv_ce) begin
         if (scnt < 128) samp[scnt] <= bus.conv_act;
         scnt <= scnt + 1;
         if (!stub_mute) begin
            for (int r = 0; r < OUT_DIM; r++)
               for (int c = 0; c < OUT_DIM; c++)
                  if (scnt == (r*S+K-1)*N + c*S+K-1 + stub_lat) begin
                     acc = '0;
                     for (int i = 0; i < K; i++)
                        for (int j = 0; j < K; j++)
                           acc += 32'(bus.conv_weight[16*(i*K+j) +: 16])
                                * 32'(samp[(r*S+i)*N + c*S+j]);
                     bus.valid_conv <= 1'b1;
                     bus.conv_op    <= acc;
                     if (r == OUT_DIM-1 && c == OUT_DIM-1) bus.end_conv <= 1'b1;
                  end
            if (stub_extra && scnt == N*N + stub_lat) begin
               bus.valid_conv <= 1'b1;
               bus.conv_op    <= 32'hbad0_bad0;
            end
         end
      end
   end

   // observation of one frame
   int   rd_addr_q [$];
   int   rd_cyc_q  [$];
   int   wr_addr_q [$];
   logic [31:0] wr_data_q [$];
   int   n_rst, n_done, n_done_busy, n_wready, n_ce;

   always @(negedge clk) begin
      if (!global_rst) begin
         if (bus.act_rd_en) begin
            rd_addr_q.push_back(int'(bus.act_addr));
            rd_cyc_q.push_back(cyc);
         end
         if (bus.res_wr_en) begin
            wr_addr_q.push_back(int'(bus.res_addr));
            wr_data_q.push_back(bus.res_wr_data);
         end
         if (bus.conv_rst) n_rst++;
         if (bus.done) begin
            n_done++;
            if (bus.busy) n_done_busy++;
         end
         if (bus.w_ready) n_wready++;
         if (bus.conv_ce) n_ce++;
      end
   end

   task automatic chk(input string tag, input logic [255:0] obs,
                      input logic [255:0] expv);
      n_checks++;
      assert (obs === expv) else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] ref_out(input int r, input int c);
      logic [31:0] s = '0;
      for (int i = 0; i < K; i++)
         for (int j = 0; j < K; j++)
            s += 32'(wts[i*K+j]) * 32'(act_mem[(r*S+i)*N + c*S+j]);
      return s;
   endfunction

   function automatic logic [16*K*K-1:0] ref_pack();
      logic [16*K*K-1:0] p = '0;
      for (int i = 0; i < K*K; i++) p[16*i +: 16] = wts[i];
      return p;
   endfunction

   task automatic chk_zero(input string p);
      chk({p, "_busy"},     bus.busy,        0);
      chk({p, "_done"},     bus.done,        0);
      chk({p, "_err"},      bus.err,         0);
      chk({p, "_w_ready"},  bus.w_ready,     0);
      chk({p, "_rd_en"},    bus.act_rd_en,   0);
      chk({p, "_act_addr"}, bus.act_addr,    0);
      chk({p, "_conv_rst"}, bus.conv_rst,    0);
      chk({p, "_conv_ce"},  bus.conv_ce,     0);
      chk({p, "_weight"},   bus.conv_weight, 0);
      chk({p, "_conv_act"}, bus.conv_act,    0);
      chk({p, "_wr_en"},    bus.res_wr_en,   0);
      chk({p, "_res_addr"}, bus.res_addr,    0);
      chk({p, "_res_data"}, bus.res_wr_data, 0);
   endtask

   // wpat 0: w_valid always high; 1: w_valid toggles 1,0,1,...
   task automatic run_frame(input bit reuse, input int wpat, input bit hold);
      int  widx = 0;
      int  n = 0;
      bit  tog = 1'b1;
      bit  got_done = 1'b0;
      @(negedge clk);
      bus.start   = 1'b1;
      bus.reuse_w = reuse;
      rd_addr_q = {}; rd_cyc_q = {}; wr_addr_q = {}; wr_data_q = {};
      n_rst = 0; n_done = 0; n_done_busy = 0; n_wready = 0; n_ce = 0;
      @(negedge clk);
      chk("busy_after_start", bus.busy, 1);
      chk("err_cleared", bus.err, 0);
      if (!hold) bus.start = 1'b0;
      bus.reuse_w = 1'($urandom);
      while (n < 400) begin
         if (bus.done) begin
            got_done = 1'b1;
            break;
         end
         bus.w_valid = (wpat == 0) ? 1'b1 : tog;
         tog = ~tog;
         bus.w_data = (bus.w_valid && bus.w_ready && widx < K*K)
                    ? wts[widx] : 16'($urandom);
         if (bus.w_valid && bus.w_ready) widx++;
         @(negedge clk);
         n++;
      end
      bus.start   = 1'b0;
      bus.w_valid = 1'b0;
      chk("frame_done_seen", got_done, 1);
      repeat (2) @(negedge clk);
   endtask

   task automatic check_frame(input bit exp_err, input int exp_wready,
                              input int exp_wr, input int exp_ce);
      int bad = 0;
      chk("done_pulses", n_done, 1);
      chk("busy_in_done", n_done_busy, 0);
      chk("conv_rst_pulses", n_rst, 1);
      chk("load_w_cycles", n_wready, exp_wready);
      chk("rd_count", rd_addr_q.size(), N*N);
      foreach (rd_addr_q[k])
         if (rd_addr_q[k] != k || rd_cyc_q[k] != rd_cyc_q[0] + k) bad++;
      chk("rd_sequence", bad, 0);
      chk("wr_count", wr_addr_q.size(), exp_wr);
      for (int k = 0; k < wr_addr_q.size() && k < exp_wr; k++) begin
         chk("wr_addr", wr_addr_q[k], k);
         chk("wr_data", wr_data_q[k], ref_out(k / OUT_DIM, k % OUT_DIM));
      end
      chk("err_at_end", bus.err, exp_err);
      chk("weights_packed", bus.conv_weight, ref_pack());
      chk("end_flag", bus.end_flag, !exp_err);
      chk("busy_idle", bus.busy, 0);
      if (exp_ce >= 0) chk("conv_ce_cycles", n_ce, exp_ce);
   endtask

   task automatic randomize_data();
      for (int i = 0; i < K*K; i++) wts[i] = 16'($urandom);
      for (int i = 0; i < N*N; i++) act_mem[i] = 16'($urandom);
   endtask

   initial begin
      int n;
      logic [143:0] basic_w;
      global_rst  = 1'b1;
      bus.start   = 1'b0;
      bus.reuse_w = 1'b0;
      bus.w_valid = 1'b0;
      bus.w_data  = '0;
      stub_mute   = 1'b0;
      stub_extra  = 1'b0;
      stub_lat    = 2;
      repeat (3) @(negedge clk);
      chk_zero("por");
      chk("por_end_flag", bus.end_flag, 0);
      global_rst = 1'b0;
      @(negedge clk);

      // basic frame: weights 0..8, RAM[i] = i
      for (int i = 0; i < K*K; i++) wts[i] = 16'(i);
      for (int i = 0; i < N*N; i++) act_mem[i] = 16'(i);
      run_frame(1'b0, 0, 1'b0);
      check_frame(1'b0, K*K, EXP, -1);
      basic_w = 144'h0008_0007_0006_0005_0004_0003_0002_0001_0000;
      chk("basic_weights", bus.conv_weight, basic_w);

      // weight backpressure with random data
      randomize_data();
      stub_lat = $urandom_range(1, 4);
      run_frame(1'b0, 1, 1'b0);
      check_frame(1'b0, 2*K*K - 1, EXP, -1);

      // weight reuse with w_valid held high
      run_frame(1'b1, 0, 1'b0);
      check_frame(1'b0, 0, EXP, -1);

      // watchdog: convolver never answers
      stub_mute = 1'b1;
      run_frame(1'b1, 0, 1'b0);
      check_frame(1'b1, 0, 0, (N*N - 1) + 64);
      stub_mute = 1'b0;

      // start held through the whole frame, plus a late spurious valid_conv
      randomize_data();
      stub_extra = 1'b1;
      stub_lat   = $urandom_range(1, 4);
      run_frame(1'b0, 0, 1'b1);
      check_frame(1'b0, K*K, EXP, -1);
      stub_extra = 1'b0;

      // reset in the middle of STREAM
      @(negedge clk);
      bus.start   = 1'b1;
      bus.reuse_w = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      n = 0;
      while (!(bus.act_rd_en && bus.act_addr == 10'd5) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("reach_stream", bus.act_addr, 5);
      n_done = 0;
      global_rst = 1'b1;
      repeat (2) @(negedge clk);
      chk_zero("midrst");
      global_rst = 1'b0;
      repeat (6) @(negedge clk);
      chk("midrst_no_done", n_done, 0);
      chk("midrst_busy", bus.busy, 0);

      // random frames after the abort
      for (int f = 0; f < 3; f++) begin
         int wpat;
         randomize_data();
         stub_lat = $urandom_range(1, 4);
         wpat = $urandom_range(0, 1);
         run_frame(1'b0, wpat, 1'b0);
         check_frame(1'b0, (wpat == 1) ? 2*K*K - 1 : K*K, EXP, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end
endmodule
